// File: rtl/mem_writer_if.sv
// Byte-stream in / memory-write out bus of mem_writer.
// master = stream source and memory side, slave = mem_writer.
interface mem_writer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   count;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  busy;
   logic                  done;
   logic [7:0]            checksum;

   modport master (
      output start, base_addr, count, in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
   );

   modport slave (
      input  start, base_addr, count, in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
   );
endinterface

// File: rtl/mem_writer.sv
// Assembles a byte stream little-endian into words and writes them to consecutive addresses.
// Optional running byte checksum: define MEM_WRITER_CHECKSUM_EN.
module mem_writer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input logic          clk,
   input logic          reset,
   mem_writer_if.slave  bus
);
   localparam int unsigned BPW   = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      remain_q, remain_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  in_ready_q, mem_we_q, busy_q, done_q;
   logic                  in_ready_d, mem_we_d, busy_d, done_d;
`ifdef MEM_WRITER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   // Next-state and datapath; status outputs are registered from the next state
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      word_d   = word_q;
      idx_d    = idx_q;
`ifdef MEM_WRITER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_d   = bus.base_addr;
               remain_d = bus.count;
               idx_d    = '0;
`ifdef MEM_WRITER_CHECKSUM_EN
               csum_d   = 8'h00;
`endif
               state_d  = (bus.count == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (bus.in_valid) begin
               for (int unsigned k = 0; k < BPW; k++) begin
                  if (idx_q == IDX_W'(k)) word_d[8*k +: 8] = bus.in_data;
               end
`ifdef MEM_WRITER_CHECKSUM_EN
               csum_d = csum_q + bus.in_data;
`endif
               if (idx_q == IDX_W'(BPW - 1)) begin
                  idx_d   = '0;
                  state_d = WRITE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         WRITE: begin
            remain_d = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
               state_d = DONE;
            end else begin
               // Address wraps naturally at 2^ADDR_WIDTH
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = COLLECT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == COLLECT);
      mem_we_d   = (state_d == WRITE);
      busy_d     = (state_d == COLLECT) || (state_d == WRITE);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         word_q     <= '0;
         idx_q      <= '0;
         in_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MEM_WRITER_CHECKSUM_EN
         csum_q     <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         in_ready_q <= in_ready_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef MEM_WRITER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = word_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
`ifdef MEM_WRITER_CHECKSUM_EN
   assign bus.checksum  = csum_q;
`else
   assign bus.checksum  = 8'h00;
`endif
endmodule

// File: tb/tb_mem_writer.sv
// Self-checking bench for mem_writer (DATA_WIDTH=32, ADDR_WIDTH=8).
// Expected writes are derived from the byte list, base address and word count.
module tb_mem_writer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mem_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

   mem_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t wr_q[$];

   typedef struct {
      logic [7:0]  base;
      logic [8:0]  cnt;
      int          pct;
      logic [7:0]  exp_first;
      logic [7:0]  exp_last;
      logic [31:0] exp_word0;
      logic [7:0]  exp_csum;
      int          exp_cycles;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Capture every memory write; the stream must be stalled during it
   always @(negedge clk) begin
      if (bus.mem_we) begin
         wr_q.push_back('{bus.mem_addr, bus.mem_wdata});
         chk("in_ready_during_write", 64'(bus.in_ready), 64'(0));
      end
   end

   function automatic logic [7:0] model_csum(input logic [7:0] bytes[$]);
      logic [7:0] s = 8'h00;
`ifdef MEM_WRITER_CHECKSUM_EN
      foreach (bytes[i]) s = s + bytes[i];
`endif
      return s;
   endfunction

   task automatic run_load(input logic [7:0] base, input logic [8:0] cnt,
                           input logic [7:0] bytes[$], input int pct, input int mid_start,
                           output int cycles, output bit saw_ready);
      int idx = 0;
      bit got_done = 0;
      cycles = 0;
      saw_ready = 0;
      wr_q.delete();
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = base; bus.count = cnt; bus.in_valid = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (!got_done && cycles < 3000) begin
         if (cycles == mid_start) begin
            bus.start = 1'b1; bus.base_addr = 8'h80; bus.count = 9'd5;
         end else begin
            bus.start = 1'b0;
         end
         if (idx < bytes.size() && $urandom_range(99) < 32'(pct)) begin
            bus.in_valid = 1'b1; bus.in_data = bytes[idx];
         end else begin
            bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
         end
         @(negedge clk);
         if (bus.in_ready) saw_ready = 1;
         if (bus.in_valid && bus.in_ready) idx++;
         if (bus.done) got_done = 1;
         @(posedge clk); #1;
         cycles++;
      end
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
      if (!got_done) chk("done_timeout", 64'(0), 64'(1));
   endtask

   task automatic verify_load(input string nm, input logic [7:0] base, input logic [8:0] cnt,
                              input logic [7:0] bytes[$]);
      chk({nm, "_nwrites"}, 64'(wr_q.size()), 64'(cnt));
      for (int w = 0; w < wr_q.size() && w < int'(cnt); w++) begin
         logic [31:0] ew = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
         logic [7:0]  ea = 8'(32'(base) + 32'(w));
         chk({nm, "_addr"}, 64'(wr_q[w].a), 64'(ea));
         chk({nm, "_data"}, 64'(wr_q[w].d), 64'(ew));
      end
      chk({nm, "_csum"}, 64'(bus.checksum), 64'(model_csum(bytes)));
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, 64'(bus.done), 64'(0));
      chk({nm, "_busy_after"}, 64'(bus.busy), 64'(0));
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'(0));
      chk({nm, "_mem_we"}, 64'(bus.mem_we), 64'(0));
      chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
      chk({nm, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
      chk({nm, "_busy"}, 64'(bus.busy), 64'(0));
      chk({nm, "_done"}, 64'(bus.done), 64'(0));
      chk({nm, "_checksum"}, 64'(bus.checksum), 64'(0));
   endtask

   initial begin
      logic [7:0] bytes[$];
      logic [7:0] csum_hold;
      int         cyc;
      bit         saw;
      int         idx;

      bus.start = 1'b0; bus.base_addr = '0; bus.count = '0;
      bus.in_data = '0; bus.in_valid = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed table: single word, backpressure, wrap, zero count, full memory
      tbl[0] = '{8'h10, 9'd1,   100, 8'h10, 8'h10, 32'h44332211, 8'hAA, 6};
      tbl[1] = '{8'h10, 9'd2,   60,  8'h10, 8'h11, 32'h44332211, 8'h64, -1};
      tbl[2] = '{8'hFF, 9'd2,   100, 8'hFF, 8'h00, 32'h44332211, 8'h64, 11};
      tbl[3] = '{8'h20, 9'd0,   100, 8'h00, 8'h00, 32'h0,        8'h00, 1};
      tbl[4] = '{8'h00, 9'd256, 100, 8'h00, 8'hFF, 32'h44332211, 8'h00, 1281};
      for (int t = 0; t < 5; t++) begin
         bytes.delete();
         for (int i = 0; i < 4 * int'(tbl[t].cnt); i++) bytes.push_back(8'((i + 1) * 17));
         run_load(tbl[t].base, tbl[t].cnt, bytes, tbl[t].pct, -1, cyc, saw);
         if (tbl[t].exp_cycles >= 0) chk("tbl_cycles", 64'(cyc), 64'(tbl[t].exp_cycles));
         if (tbl[t].cnt != 0 && wr_q.size() > 0) begin
            chk("tbl_first_addr", 64'(wr_q[0].a), 64'(tbl[t].exp_first));
            chk("tbl_last_addr", 64'(wr_q[wr_q.size()-1].a), 64'(tbl[t].exp_last));
            chk("tbl_word0", 64'(wr_q[0].d), 64'(tbl[t].exp_word0));
         end else begin
            chk("tbl_zero_no_ready", 64'(saw), 64'(0));
         end
`ifdef MEM_WRITER_CHECKSUM_EN
         chk("tbl_csum", 64'(bus.checksum), 64'(tbl[t].exp_csum));
`endif
         verify_load("tbl", tbl[t].base, tbl[t].cnt, bytes);
      end

      // Checksum holds after done until the next start
      csum_hold = model_csum(bytes);
      repeat (3) @(negedge clk);
      chk("csum_hold", 64'(bus.checksum), 64'(csum_hold));

      // start while busy is ignored
      bytes.delete();
      for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
      run_load(8'h30, 9'd2, bytes, 100, 3, cyc, saw);
      chk("busy_start_cycles", 64'(cyc), 64'(11));
      verify_load("busy_start", 8'h30, 9'd2, bytes);

      // Randomized loads against the reference model
      for (int r = 0; r < 10; r++) begin
         logic [7:0] b = 8'($urandom);
         logic [8:0] n = 9'($urandom_range(1, 6));
         int         p = (r < 2) ? 100 : int'($urandom_range(30, 100));
         bytes.delete();
         for (int i = 0; i < 4 * int'(n); i++) bytes.push_back(8'($urandom));
         run_load(b, n, bytes, p, -1, cyc, saw);
         if (p == 100) chk("rand_cycles", 64'(cyc), 64'(5 * int'(n) + 1));
         verify_load("rand", b, n, bytes);
      end

      // Reset mid-load: one word written, then abandoned
      bytes.delete();
      for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
      wr_q.delete();
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = 8'h40; bus.count = 9'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      idx = 0;
      for (int c = 0; c < 7; c++) begin
         bus.in_valid = 1'b1; bus.in_data = bytes[idx];
         @(negedge clk);
         if (bus.in_ready) idx++;
         @(posedge clk); #1;
      end
      chk("rst_pre_busy", 64'(bus.busy), 64'(1));
      reset = 1'b1;
      #1;
      check_reset_vals("rst_mid");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk("rst_nwrites", 64'(wr_q.size()), 64'(1));
      if (wr_q.size() > 0) begin
         chk("rst_addr", 64'(wr_q[0].a), 64'(8'h40));
         chk("rst_data", 64'(wr_q[0].d), 64'({bytes[3], bytes[2], bytes[1], bytes[0]}));
      end
      @(negedge clk);
      chk("rst_idle_busy", 64'(bus.busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
